pulse_seq_ctrl: RTL

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_seq_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pulse_seq_ctrl.sv
// rtl/pulse_seq_ctrl.sv - microsecond pulse-train sequencer driving an external delay timer
// Optional watchdog on the WAIT phases: define PSEQ_WDOG_TIMEOUT_EN.
module pulse_seq_ctrl #(
  parameter int unsigned REP_W  = 8,
  parameter int unsigned WDOG_W = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [15:0]      high_us,
  input  logic [15:0]      low_us,
  input  logic [REP_W-1:0] reps,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dly_en,
  output logic [15:0]      dly_nus,
  input  logic             dly_timeup
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_H = 3'd1,
    S_WAIT_H = 3'd2,
    S_LOAD_L = 3'd3,
    S_WAIT_L = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  typedef struct packed {
    state_e           st;
    logic [REP_W-1:0] rem;
  } step_t;

  // Start of a high phase; a zero high time consumes the repetition without a pulse.
  function automatic step_t enter_high(input logic [15:0] h, input logic [15:0] l,
                                       input logic [REP_W-1:0] r);
    step_t s;
    s.st  = S_LOAD_H;
    s.rem = r;
    if (h == '0) begin
      if ((r == REP_W'(1)) || (l == '0)) begin
        s.st  = S_DONE;
        s.rem = '0;
      end else begin
        s.st  = S_LOAD_L;
        s.rem = r - REP_W'(1);
      end
    end
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      high_q, high_d;
  logic [15:0]      low_q, low_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [15:0]      dly_nus_q, dly_nus_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dly_en_q, dly_en_d;
  logic             blank_q;
  logic             in_wait;
  logic             accept;
  logic             wdog_to;
  step_t            step;

  assign in_wait = (state_q == S_WAIT_H) || (state_q == S_WAIT_L);
  // The first WAIT cycle may still see the previous delay's expiry level.
  assign accept  = in_wait && !blank_q && dly_timeup;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      high_q    <= '0;
      low_q     <= '0;
      rem_q     <= '0;
      dly_nus_q <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dly_en_q  <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      low_q     <= low_d;
      rem_q     <= rem_d;
      dly_nus_q <= dly_nus_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dly_en_q  <= dly_en_d;
      blank_q   <= dly_en_q;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    rem_d   = rem_q;
    step    = enter_high(high_q, low_q, rem_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          high_d = high_us;
          low_d  = low_us;
          rem_d  = reps;
          if (reps == '0) begin
            state_d = S_DONE;
          end else begin
            step    = enter_high(high_us, low_us, reps);
            state_d = step.st;
            rem_d   = step.rem;
          end
        end
      end
      S_LOAD_H: state_d = S_WAIT_H;
      S_WAIT_H: begin
        if (accept) begin
          rem_d = rem_q - REP_W'(1);
          if (rem_d == '0) begin
            state_d = S_DONE;
          end else if (low_q != '0) begin
            state_d = S_LOAD_L;
          end else begin
            state_d = S_LOAD_H;
          end
        end else if (wdog_to) begin
          state_d = S_DONE;
        end
      end
      S_LOAD_L: state_d = S_WAIT_L;
      S_WAIT_L: begin
        if (accept) begin
          state_d = step.st;
          rem_d   = step.rem;
        end else if (wdog_to) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so their registers track state_q exactly.
  always_comb begin : output_decode
    pulse_d   = (state_d == S_LOAD_H) || (state_d == S_WAIT_H);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    dly_en_d  = (state_d == S_LOAD_H) || (state_d == S_LOAD_L);
    dly_nus_d = dly_nus_q;
    if (state_d == S_LOAD_H) begin
      dly_nus_d = high_d;
    end else if (state_d == S_LOAD_L) begin
      dly_nus_d = low_d;
    end
  end

`ifdef PSEQ_WDOG_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;

  assign wdog_to = in_wait && !accept && (&wdog_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= in_wait ? (wdog_q + WDOG_W'(1)) : '0;
      if (wdog_to) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  // No watchdog: the counter is held at zero so it can never reach all-ones.
  logic [WDOG_W-1:0] wdog_off;

  assign wdog_off = '0;
  assign wdog_to  = 1'b0;
  assign err      = &wdog_off;
`endif

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dly_en    = dly_en_q;
  assign dly_nus   = dly_nus_q;

endmodule
